// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - host push / UART handshake bundle for uart_tx_fifo
//
// Purpose: groups the host-side push port, the FIFO status flags and the
// UART-facing handshake into one bundle.
// Ports (slave = uart_tx_fifo view):
//   wr_i, dat_i       host push strobe and byte
//   full_o, empty_o   FIFO occupancy flags
//   level_o           entry count
//   overflow_o        one-cycle pulse for a dropped push
//   busy_o            FIFO non-empty or sequencer active
//   uart_wr_o         UART write strobe
//   uart_dat_o        UART byte, held from load to next load
//   uart_busy_i       UART tx_busy
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic                  full_o;
    logic                  empty_o;
    logic [DEPTH_LOG2:0]   level_o;
    logic                  overflow_o;
    logic                  busy_o;
    logic                  uart_wr_o;
    logic [DATA_WIDTH-1:0] uart_dat_o;
    logic                  uart_busy_i;

    modport slave (
        input  wr_i, dat_i, uart_busy_i,
        output full_o, empty_o, level_o, overflow_o, busy_o, uart_wr_o, uart_dat_o
    );

    modport master (
        output wr_i, dat_i, uart_busy_i,
        input  full_o, empty_o, level_o, overflow_o, busy_o, uart_wr_o, uart_dat_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and strobe sequencer feeding a UART transmitter
//
// Purpose: buffers host bytes at full clock rate and hands them one at a time
// to the UART, pacing on its tx_busy so back-to-back frames need no polling.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   uart_tx_fifo_if.slave: host push port, FIFO status, UART handshake
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                  state_q,    state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q,    level_d;
    logic                    overflow_q, overflow_d;
    logic                    uart_wr_q,  uart_wr_d;
    logic [DATA_WIDTH-1:0]   uart_dat_q, uart_dat_d;

    logic [DATA_WIDTH-1:0]   mem_q [0:DEPTH-1];

    logic full;
    logic empty;
    logic push_ok;
    logic pop;

    // Flags decode the registered level only, so no input reaches an output
    // combinationally.
    assign full  = (level_q == LEVEL_FULL);
    assign empty = (level_q == '0);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        uart_wr_d  = uart_wr_q;
        uart_dat_d = uart_dat_q;
        pop        = 1'b0;

        // Full is judged on the pre-edge level: a push while full is dropped
        // even if the sequencer pops on the same edge.
        push_ok    = bus.wr_i && !full;
        overflow_d = bus.wr_i && full;

        case (state_q)
            IDLE: begin
                if (!empty && !bus.uart_busy_i) begin
                    pop        = 1'b1;
                    uart_dat_d = mem_q[rd_ptr_q];
                    uart_wr_d  = 1'b1;
                    state_d    = STROBE;
                end
            end
            STROBE: begin
                // Strobe stays up until the UART acknowledges with tx_busy;
                // there is deliberately no timeout here.
                if (bus.uart_busy_i) begin
                    uart_wr_d = 1'b0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.uart_busy_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                uart_wr_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end

        case ({push_ok, pop})
            2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            uart_wr_q  <= 1'b0;
            uart_dat_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            uart_wr_q  <= uart_wr_d;
            uart_dat_q <= uart_dat_d;
        end
    end

    // Storage is not reset; entries outside [rd_ptr, rd_ptr+level) are never read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.dat_i;
        end
    end

    assign bus.full_o     = full;
    assign bus.empty_o    = empty;
    assign bus.level_o    = level_q;
    assign bus.overflow_o = overflow_q;
    assign bus.busy_o     = !empty || (state_q != IDLE);
    assign bus.uart_wr_o  = uart_wr_q;
    assign bus.uart_dat_o = uart_dat_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
    localparam int DW    = 8;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr  = 1'b0;
    logic [DW-1:0] dat = '0;
    logic         auto_uart = 1'b1;
    logic         ub_man    = 1'b0;
    logic         ub_auto   = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) bus ();

    assign bus.wr_i        = wr;
    assign bus.dat_i       = dat;
    assign bus.uart_busy_i = auto_uart ? ub_auto : ub_man;

    uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a byte queue plus "strobing" / "waiting for UART to
    // finish" flags, stepped from the pre-edge inputs.
    byte unsigned  m_q[$];
    logic          m_strobe = 1'b0;
    logic          m_drain  = 1'b0;
    logic          m_ovf    = 1'b0;
    logic [DW-1:0] m_dat    = '0;
    int            coincide = 0;
    int            m_sz;
    bit            m_push, m_pop, m_ub;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_strobe = 1'b0;
            m_drain  = 1'b0;
            m_ovf    = 1'b0;
            m_dat    = '0;
        end else begin
            m_ub   = bus.uart_busy_i;
            m_sz   = m_q.size();
            m_push = wr && (m_sz < DEPTH);
            m_ovf  = wr && (m_sz == DEPTH);
            m_pop  = !m_strobe && !m_drain && (m_sz > 0) && !m_ub;
            if (m_strobe && m_ub) begin
                m_strobe = 1'b0;
                m_drain  = 1'b1;
            end else if (m_drain && !m_ub) begin
                m_drain = 1'b0;
            end
            if (m_pop) begin
                m_dat    = m_q.pop_front();
                m_strobe = 1'b1;
            end
            if (m_push) m_q.push_back(dat);
            if (m_push && m_pop) coincide++;
        end
    end

    always @(negedge clk) begin
        chk("level",    32'(bus.level_o),    32'(m_q.size()));
        chk("full",     32'(bus.full_o),     32'(m_q.size() == DEPTH));
        chk("empty",    32'(bus.empty_o),    32'(m_q.size() == 0));
        chk("overflow", 32'(bus.overflow_o), 32'(m_ovf));
        chk("busy",     32'(bus.busy_o),     32'((m_q.size() > 0) || m_strobe || m_drain));
        chk("uart_wr",  32'(bus.uart_wr_o),  32'(m_strobe));
        chk("uart_dat", 32'(bus.uart_dat_o), 32'(m_dat));
    end

    // Simple UART stand-in: after seeing wr, raise tx_busy d cycles later and
    // hold it for l cycles. Captured bytes go to rx_q.
    int           u_state = 0;
    int           u_cnt   = 0;
    int           d_min = 1, d_max = 1, l_min = 1, l_max = 4;
    byte unsigned rx_q[$];

    always @(posedge clk) begin
        #1;
        if (rst) begin
            u_state = 0;
            ub_auto = 1'b0;
        end else begin
            case (u_state)
                0: if (auto_uart && bus.uart_wr_o) begin
                    rx_q.push_back(bus.uart_dat_o);
                    u_cnt   = int'($urandom_range(d_max, d_min));
                    u_state = 1;
                end
                1: begin
                    u_cnt--;
                    if (u_cnt <= 0) begin
                        ub_auto = 1'b1;
                        u_cnt   = int'($urandom_range(l_max, l_min));
                        u_state = 2;
                    end
                end
                default: begin
                    u_cnt--;
                    if (u_cnt <= 0) begin
                        ub_auto = 1'b0;
                        u_state = 0;
                    end
                end
            endcase
        end
    end

    task automatic wait_idle(input string name, input int bound);
        int i = 0;
        while (i < bound && !(m_q.size() == 0 && !m_strobe && !m_drain && u_state == 0)) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_idle_in_time"}, 32'(i < bound), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    byte unsigned sent[$];
    int           width;
    int           guard;
    int           c0;
    int           n;
    int           wr_seen;

    initial begin
        // Reset with a push strobe held high
        wr  = 1'b1;
        dat = 8'h55;
        repeat (3) @(negedge clk);
        chk("rst_level",    32'(bus.level_o),    32'd0);
        chk("rst_empty",    32'(bus.empty_o),    32'd1);
        chk("rst_full",     32'(bus.full_o),     32'd0);
        chk("rst_overflow", 32'(bus.overflow_o), 32'd0);
        chk("rst_busy",     32'(bus.busy_o),     32'd0);
        chk("rst_uart_wr",  32'(bus.uart_wr_o),  32'd0);
        chk("rst_uart_dat", 32'(bus.uart_dat_o), 32'd0);
        tick();
        rst = 1'b0;
        wr  = 1'b0;

        // Single byte, UART raises tx_busy one cycle after wr
        d_min = 1; d_max = 1; l_min = 3; l_max = 3;
        rx_q.delete();
        tick();
        wr  = 1'b1;
        dat = 8'hAF;
        tick();
        wr  = 1'b0;
        @(negedge clk);
        chk("sb_level_after_push", 32'(bus.level_o),   32'd1);
        chk("sb_wr_not_yet",       32'(bus.uart_wr_o), 32'd0);
        @(negedge clk);
        chk("sb_wr",        32'(bus.uart_wr_o),  32'd1);
        chk("sb_dat",       32'(bus.uart_dat_o), 32'hAF);
        chk("sb_level_pop", 32'(bus.level_o),    32'd0);
        width = 1;
        guard = 0;
        @(negedge clk);
        while (bus.uart_wr_o && guard < 20) begin
            width++;
            guard++;
            @(negedge clk);
        end
        chk("sb_strobe_width", 32'(width), 32'd2);
        wait_idle("sb", 100);
        chk("sb_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("sb_rx_byte", 32'(rx_q[0]), 32'hAF);

        // Burst 01..05 with randomised UART timing
        d_min = 1; d_max = 3; l_min = 1; l_max = 5;
        rx_q.delete();
        tick();
        for (int i = 1; i <= 5; i++) begin
            wr  = 1'b1;
            dat = DW'(i);
            tick();
        end
        wr = 1'b0;
        wait_idle("burst", 500);
        chk("burst_rx_count", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            chk("burst_rx_byte", 32'(rx_q[i]), 32'(i + 1));

        // Full / overflow with the UART held busy
        rx_q.delete();
        sent.delete();
        tick();
        auto_uart = 1'b0;
        ub_man    = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr  = 1'b1;
            dat = DW'($urandom);
            sent.push_back(dat);
            tick();
            if (i == 15) begin
                chk("full_level16", 32'(bus.level_o), 32'd16);
                chk("full_flag",    32'(bus.full_o),  32'd1);
            end
        end
        wr = 1'b0;
        chk("ovf_pulse",       32'(bus.overflow_o), 32'd1);
        chk("ovf_level_kept",  32'(bus.level_o),    32'd16);
        tick();
        chk("ovf_pulse_end",   32'(bus.overflow_o), 32'd0);
        ub_man    = 1'b0;
        auto_uart = 1'b1;
        wait_idle("full", 800);
        chk("full_rx_count", 32'(rx_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++)
            chk("full_rx_byte", 32'(rx_q[i]), 32'(sent[i]));

        // Wrap and concurrent push/pop, 40 random bytes
        d_min = 1; d_max = 1; l_min = 1; l_max = 2;
        rx_q.delete();
        sent.delete();
        c0 = coincide;
        n  = 0;
        guard = 0;
        tick();
        while (n < 40 && guard < 2000) begin
            if ($urandom_range(3, 0) != 0 && m_q.size() < DEPTH) begin
                wr  = 1'b1;
                dat = DW'($urandom);
                sent.push_back(dat);
                n++;
            end else begin
                wr = 1'b0;
            end
            tick();
            guard++;
        end
        wr = 1'b0;
        wait_idle("wrap", 1000);
        chk("wrap_rx_count", 32'(rx_q.size()), 32'd40);
        for (int i = 0; i < 40 && i < rx_q.size(); i++)
            chk("wrap_rx_byte", 32'(rx_q[i]), 32'(sent[i]));
        chk("wrap_push_pop_same_edge", 32'(coincide > c0), 32'd1);

        // Reset while in STROBE
        d_min = 6; d_max = 6; l_min = 2; l_max = 2;
        rx_q.delete();
        tick();
        foreach (sent[i]) sent.delete(i);
        wr = 1'b1; dat = 8'h11; tick();
        dat = 8'h22; tick();
        dat = 8'h33; tick();
        wr = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!bus.uart_wr_o && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        chk("mid_strobe_reached", 32'(guard < 20), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_uart_wr", 32'(bus.uart_wr_o), 32'd0);
        chk("mid_rst_empty",   32'(bus.empty_o),   32'd1);
        chk("mid_rst_level",   32'(bus.level_o),   32'd0);
        chk("mid_rst_busy",    32'(bus.busy_o),    32'd0);
        tick();
        rst = 1'b0;
        wr_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.uart_wr_o) wr_seen++;
        end
        chk("mid_no_more_strobes", 32'(wr_seen), 32'd0);
        chk("mid_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("mid_rx_first", 32'(rx_q[0]), 32'h11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO and handshake sequencer that sits directly upstream of the `UART` transmitter. The host writes bytes at full clock rate. The block buffers them and feeds them one at a time into the UART's `wr_i`/`dat_i` inputs, pacing on `tx_busy`, so back-to-back bytes go out without host polling. It shares `clk`/`rst` with the `UART` instance.

## Interface
- `DATA_WIDTH`, 8, byte width; must match the UART `dat_i` width.
- `DEPTH_LOG2`, 4, FIFO depth = 2**DEPTH_LOG2 entries (16).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_i`  in  1  host push strobe, sampled each rising edge.
- `dat_i`  in  DATA_WIDTH  host byte, captured when the push is accepted.
- `full_o`  out  1  FIFO holds 2**DEPTH_LOG2 entries.
- `empty_o`  out  1  FIFO holds 0 entries.
- `level_o`  out  DEPTH_LOG2+1  current entry count.
- `overflow_o`  out  1  one-cycle pulse when a push is dropped.
- `busy_o`  out  1  high when the FIFO is non-empty or the sequencer is not in IDLE.
- `uart_wr_o`  out  1  connects to UART `wr_i`.
- `uart_dat_o`  out  DATA_WIDTH  connects to UART `dat_i`; held stable from load until the next load.
- `uart_busy_i`  in  1  connects to UART `tx_busy`.

## Operation
- Storage: a circular buffer with read and write pointers of DEPTH_LOG2 bits that wrap modulo depth. A separate counter `level` tracks the entry count (DEPTH_LOG2+1 bits).
- Push: when `wr_i`=1 and `full_o`=0 at an edge, write `dat_i` at the write pointer, increment the write pointer, and increment `level`.
- Push when full: the byte is dropped and nothing changes, except that `overflow_o`=1 for the following cycle.
- `full_o` is evaluated on the pre-edge level. A push while full is dropped even if a pop happens on the same edge.
- Simultaneous accepted push and pop: `level` is unchanged and both pointers advance.
- Sequencer states:
  - IDLE: if `empty_o`=0 and `uart_busy_i`=0, then load `uart_dat_o` from the read pointer, increment the read pointer, decrement `level`, set `uart_wr_o`=1, and go to STROBE.
  - STROBE: hold `uart_wr_o`=1 until `uart_busy_i`=1 is sampled. Then set `uart_wr_o`=0 and go to DRAIN.
  - DRAIN: wait for `uart_busy_i`=0, then go to IDLE.
- There is no timeout. If the UART never raises `tx_busy`, the block stays in STROBE. This is the accepted behaviour.
- A pop from an empty FIFO is impossible by construction.

## Timing
- Reset values:
  - `full_o`=0, `empty_o`=1, `level_o`=0, `overflow_o`=0, `busy_o`=0, `uart_wr_o`=0, `uart_dat_o`=0.
  - Pointers are 0 and the state is IDLE.
  - Memory contents are not reset.
- All outputs are registered or decoded from registers only. There are no combinational paths from inputs to outputs.
- Push to UART strobe latency:
  - A push accepted at edge N into an empty FIFO with the UART idle makes `level_o`=1 after edge N.
  - IDLE pops at edge N+1, so `uart_wr_o` and `uart_dat_o` become valid after edge N+1. This is 1 cycle of added latency.
- Strobe length: a minimum of 1 cycle, extended until `uart_busy_i` is seen high.
  - With the UART `tx_busy` rising one cycle after `wr_i`, the strobe is 2 cycles wide.
- Inter-byte gap: after `uart_busy_i` falls at edge M, DRAIN→IDLE happens at edge M. The next byte loads at edge M+1, so `uart_wr_o` rises after edge M+1.
- Wrap-around: pointers roll from depth-1 to 0 with no gap, bubble or data loss.
- Reset mid-operation: every register returns to its reset value immediately (asynchronously) and the queued bytes are discarded. Aborting a frame already inside the UART is the UART's own reset behaviour.

## Test plan
- Reset: assert `rst` with `wr_i`=1 -> all outputs at reset values; no push occurs while `rst`=1.
- Single byte: push 8'hAF into an empty FIFO with the UART idle -> `uart_wr_o`=1 and `uart_dat_o`=8'hAF one cycle after the push edge. `uart_wr_o` drops on the edge where `uart_busy_i`=1 is sampled, and `level_o` returns to 0.
- Burst order: push 8'h01..8'h05 on consecutive cycles -> the UART receives 01,02,03,04,05 in order. Each `uart_wr_o` rises only after the previous `uart_busy_i` has fallen, and `busy_o` stays high until the last frame completes.
- Full/overflow: hold `uart_busy_i`=1 and push 17 bytes -> `full_o`=1 after 16 pushes and `level_o`=16. The 17th push pulses `overflow_o` for 1 cycle, and the contents are unchanged.
- Wrap and concurrency: run 40 bytes through with a push and a pop landing on the same edge -> `level_o` stays unchanged on those edges, the pointers wrap past 15→0, and the output sequence matches the input exactly.
- Reset mid-burst: queue 8'h11, 8'h22, 8'h33, then pulse `rst` while in STROBE -> `uart_wr_o`=0 and `empty_o`=1 immediately, and no further bytes are issued.
